// File: rtl/mips_mc_core_if.sv
// rtl/mips_mc_core_if.sv - req/ack memory port shared by mips_mc_core and its memory
interface mips_mc_core_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/mips_mc_core.sv
// rtl/mips_mc_core.sv - multi-cycle MIPS-subset core with clock-enable and req/ack memory port
// MIPS_MC_CORE_TRAP_EN: unrecognised instructions halt the core instead of executing as NOP.
module mips_mc_core #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [4:0]  DBG_REG  = 5'd2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    mips_mc_core_if.master        mem,
    output logic [31:0]           pc,
    output logic [31:0]           dbg_reg,
    output logic                  halted
);
`ifdef MIPS_MC_CORE_TRAP_EN
    localparam logic TRAP_EN = 1'b1;
`else
    localparam logic TRAP_EN = 1'b0;
`endif

    localparam logic [5:0] OP_R = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04;
    localparam logic [5:0] OP_BNE = 6'h05, OP_ADDI = 6'h08, OP_ADDIU = 6'h09, OP_SLTI = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B, OP_ANDI = 6'h0C, OP_ORI = 6'h0D, OP_XORI = 6'h0E;
    localparam logic [5:0] OP_LUI = 6'h0F, OP_LW = 6'h23, OP_SW = 6'h2B;
    localparam logic [5:0] F_SLL = 6'h00, F_SRL = 6'h02, F_SRA = 6'h03, F_JR = 6'h08;
    localparam logic [5:0] F_ADD = 6'h20, F_ADDU = 6'h21, F_SUB = 6'h22, F_SUBU = 6'h23;
    localparam logic [5:0] F_AND = 6'h24, F_OR = 6'h25, F_XOR = 6'h26, F_NOR = 6'h27;
    localparam logic [5:0] F_SLT = 6'h2A, F_SLTU = 6'h2B;

    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, ir_q, a_q, b_q, alu_q;
    logic        ovf_q;
    logic [31:0] rf_q [0:31];

    logic [5:0]  op, fn;
    logic [4:0]  rs, rt, rd, shamt, wb_dst;
    logic [31:0] imm_sext, imm_zext, pc_plus4, jtarget, br_target, rf_rs, rf_rt;
    logic        is_r, is_j, is_jal, is_jr, is_br, is_lw, is_sw, legal, br_taken;
    logic [31:0] opb, sum, diff, alu_res;
    logic        alu_ovf;

    assign op        = ir_q[31:26];
    assign rs        = ir_q[25:21];
    assign rt        = ir_q[20:16];
    assign rd        = ir_q[15:11];
    assign shamt     = ir_q[10:6];
    assign fn        = ir_q[5:0];
    assign imm_sext  = {{16{ir_q[15]}}, ir_q[15:0]};
    assign imm_zext  = {16'h0000, ir_q[15:0]};
    assign pc_plus4  = pc_q + 32'd4;
    assign jtarget   = {pc_plus4[31:28], ir_q[25:0], 2'b00};
    assign br_target = pc_plus4 + {imm_sext[29:0], 2'b00};
    assign rf_rs     = rf_q[rs];
    assign rf_rt     = rf_q[rt];
    assign is_r      = (op == OP_R);
    assign is_j      = (op == OP_J);
    assign is_jal    = (op == OP_JAL);
    assign is_jr     = is_r && (fn == F_JR);
    assign is_br     = (op == OP_BEQ) || (op == OP_BNE);
    assign is_lw     = (op == OP_LW);
    assign is_sw     = (op == OP_SW);
    assign br_taken  = (op == OP_BEQ) ? (a_q == b_q) : (a_q != b_q);
    assign wb_dst    = is_r ? rd : rt;
    assign pc        = pc_q;
    assign dbg_reg   = rf_q[DBG_REG];

    always_comb begin
        legal = 1'b0;
        if (is_r) begin
            legal = fn inside {F_SLL, F_SRL, F_SRA, F_JR, F_ADD, F_ADDU, F_SUB, F_SUBU,
                               F_AND, F_OR, F_XOR, F_NOR, F_SLT, F_SLTU};
        end else begin
            legal = op inside {OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDI, OP_ADDIU, OP_SLTI,
                               OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI, OP_LW, OP_SW};
        end
    end

    // Immediate ALU ops take the extended immediate; R-type, branches compare/operate on B.
    always_comb begin
        opb = b_q;
        if (!is_r && !is_br) begin
            opb = (op == OP_ANDI || op == OP_ORI || op == OP_XORI) ? imm_zext : imm_sext;
        end
        sum     = a_q + opb;
        diff    = a_q - opb;
        alu_res = sum;
        alu_ovf = 1'b0;
        if (is_r) begin
            case (fn)
                F_ADD:  alu_ovf = (a_q[31] == opb[31]) && (sum[31] != a_q[31]);
                F_SUB:  begin
                    alu_res = diff;
                    alu_ovf = (a_q[31] != opb[31]) && (diff[31] != a_q[31]);
                end
                F_SUBU: alu_res = diff;
                F_AND:  alu_res = a_q & opb;
                F_OR:   alu_res = a_q | opb;
                F_XOR:  alu_res = a_q ^ opb;
                F_NOR:  alu_res = ~(a_q | opb);
                F_SLT:  alu_res = {31'd0, $signed(a_q) < $signed(opb)};
                F_SLTU: alu_res = {31'd0, a_q < opb};
                F_SLL:  alu_res = b_q << shamt;
                F_SRL:  alu_res = b_q >> shamt;
                F_SRA:  alu_res = $unsigned($signed(b_q) >>> shamt);
                default: ;
            endcase
        end else begin
            case (op)
                OP_ADDI:  alu_ovf = (a_q[31] == opb[31]) && (sum[31] != a_q[31]);
                OP_SLTI:  alu_res = {31'd0, $signed(a_q) < $signed(opb)};
                OP_SLTIU: alu_res = {31'd0, a_q < opb};
                OP_ANDI:  alu_res = a_q & opb;
                OP_ORI:   alu_res = a_q | opb;
                OP_XORI:  alu_res = a_q ^ opb;
                OP_LUI:   alu_res = {ir_q[15:0], 16'h0000};
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
        end else if (en) begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  if (mem.mem_ack) state_d = S_DECODE;
            S_DECODE: begin
                if (!legal)                      state_d = TRAP_EN ? S_HALT : S_FETCH;
                else if (is_j || is_jal || is_jr) state_d = S_FETCH;
                else                             state_d = S_EXEC;
            end
            S_EXEC: begin
                if (is_br)               state_d = S_FETCH;
                else if (is_lw || is_sw) state_d = S_MEM;
                else                     state_d = S_WB;
            end
            S_MEM:    if (mem.mem_ack) state_d = is_sw ? S_FETCH : S_WB;
            S_WB:     state_d = S_FETCH;
            default:  state_d = S_HALT;
        endcase
    end

    // Bus outputs come only from registered state; rst masks the request at once.
    always_comb begin
        mem.mem_req   = 1'b0;
        mem.mem_we    = 1'b0;
        mem.mem_addr  = pc_q;
        mem.mem_wdata = b_q;
        halted        = TRAP_EN && (state_q == S_HALT);
        if (!rst) begin
            case (state_q)
                S_FETCH: mem.mem_req = 1'b1;
                S_MEM: begin
                    mem.mem_req  = 1'b1;
                    mem.mem_we   = is_sw;
                    mem.mem_addr = {alu_q[31:2], 2'b00};
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q  <= RESET_PC;
            ir_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
            alu_q <= '0;
            ovf_q <= 1'b0;
            for (int i = 0; i < 32; i++) rf_q[i] <= '0;
        end else if (en) begin
            case (state_q)
                S_FETCH: if (mem.mem_ack) ir_q <= mem.mem_rdata;
                S_DECODE: begin
                    a_q <= rf_rs;
                    b_q <= rf_rt;
                    if (!legal) begin
                        if (!TRAP_EN) pc_q <= pc_plus4;
                    end else if (is_jr) begin
                        pc_q <= rf_rs;
                    end else if (is_j || is_jal) begin
                        pc_q <= jtarget;
                        if (is_jal) rf_q[31] <= pc_plus4;
                    end
                end
                S_EXEC: begin
                    alu_q <= alu_res;
                    ovf_q <= alu_ovf;
                    if (is_br) pc_q <= br_taken ? br_target : pc_plus4;
                end
                S_MEM: if (mem.mem_ack) begin
                    if (is_sw) pc_q <= pc_plus4;
                    else       alu_q <= mem.mem_rdata;
                end
                S_WB: begin
                    if (!ovf_q && wb_dst != 5'd0) rf_q[wb_dst] <= alu_q;
                    pc_q <= pc_plus4;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mips_mc_core.sv
// tb/tb_mips_mc_core.sv - self-checking bench for mips_mc_core with a store scoreboard
module tb_mips_mc_core;
    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } word_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en  = 1'b1;
    logic [31:0] pc, dbg_reg;
    logic        halted;

    logic [3:0]  wait_cycles = 4'd0;
    logic [3:0]  wait_cnt;
    logic        load_en = 1'b0;
    logic [31:0] load_addr = '0, load_data = '0;
    logic [31:0] mem [0:1023];

    word_t       prog_q[$];
    word_t       sb_q[$];
    word_t       sb_e;
    int          errors = 0;
    int          checks = 0;

    mips_mc_core_if mem_if();

    mips_mc_core #(.RESET_PC(32'h0), .DBG_REG(5'd2)) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .mem     (mem_if),
        .pc      (pc),
        .dbg_reg (dbg_reg),
        .halted  (halted)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    assign mem_if.mem_ack   = mem_if.mem_req && (wait_cnt >= wait_cycles);
    assign mem_if.mem_rdata = mem[mem_if.mem_addr[11:2]];

    // Variable-latency memory; a store commits only on an enabled ack edge.
    always @(posedge clk) begin
        if (load_en) mem[load_addr[11:2]] <= load_data;
        if (rst) begin
            wait_cnt <= 4'd0;
        end else if (mem_if.mem_req) begin
            if (!mem_if.mem_ack) begin
                wait_cnt <= wait_cnt + 4'd1;
            end else if (en) begin
                wait_cnt <= 4'd0;
                if (mem_if.mem_we) begin
                    mem[mem_if.mem_addr[11:2]] <= mem_if.mem_wdata;
                    if (sb_q.size() == 0) begin
                        check("sb_extra_store", 32'(sb_q.size()), 32'd1);
                    end else begin
                        sb_e = sb_q.pop_front();
                        check("sb_addr", mem_if.mem_addr, sb_e.addr);
                        check("sb_data", mem_if.mem_wdata, sb_e.data);
                    end
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pw(input logic [31:0] a, input logic [31:0] d);
        word_t w;
        w.addr = a;
        w.data = d;
        prog_q.push_back(w);
    endtask

    task automatic expect_store(input logic [31:0] a, input logic [31:0] d);
        word_t w;
        w.addr = a;
        w.data = d;
        sb_q.push_back(w);
    endtask

    task automatic start_test(input logic [3:0] w);
        word_t e;
        @(negedge clk);
        rst = 1'b1;
        tick(1);
        check("rst_pc", pc, 32'h0);
        check("rst_dbg", dbg_reg, 32'h0);
        check("rst_req", 32'(mem_if.mem_req), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        while (prog_q.size() > 0) begin
            e = prog_q.pop_front();
            load_en   = 1'b1;
            load_addr = e.addr;
            load_data = e.data;
            tick(1);
        end
        load_en     = 1'b0;
        wait_cycles = w;
        rst         = 1'b0;
        #1;
        check("first_req", 32'(mem_if.mem_req), 32'd1);
        check("first_addr", mem_if.mem_addr, 32'h0);
    endtask

    task automatic wait_pc(input string tag, input logic [31:0] target, input int budget);
        int n = 0;
        while (pc !== target && n < budget) begin
            tick(1);
            n++;
        end
        check(tag, pc, target);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic stalled;
        int   n;

        // Reset during a pending fetch.
        wait_cycles = 4'd5;
        tick(2);
        rst = 1'b0;
        #1;
        check("fetch_pending", 32'(mem_if.mem_req), 32'd1);
        tick(2);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("rst_mid_req", 32'(mem_if.mem_req), 32'd0);
            check("rst_mid_we", 32'(mem_if.mem_we), 32'd0);
            tick(1);
        end

        // Arithmetic, zero-wait memory.
        pw(32'h00, 32'h2402_0005);   // ADDIU $2,$0,5
        pw(32'h04, 32'h0042_1021);   // ADDU  $2,$2,$2
        pw(32'h08, 32'h2400_0007);   // ADDIU $0,$0,7
        pw(32'h0C, 32'h0002_1021);   // ADDU  $2,$0,$2
        pw(32'h10, 32'h1000_FFFF);   // park
        start_test(4'd0);
        tick(8);
        check("arith_dbg_c8", dbg_reg, 32'd10);
        tick(4);
        check("arith_pc_c12", pc, 32'd12);
        tick(4);
        check("zero_reg", dbg_reg, 32'd10);
        check("arith_pc_c16", pc, 32'd16);

        // Store/load with 3 wait cycles and one en=0 cycle while ack is up.
        pw(32'h00, 32'h3C01_DEAD);   // LUI $1,0xDEAD
        pw(32'h04, 32'h3421_BEEF);   // ORI $1,$1,0xBEEF
        pw(32'h08, 32'hAC01_0100);   // SW  $1,0x100($0)
        pw(32'h0C, 32'h8C02_0100);   // LW  $2,0x100($0)
        pw(32'h10, 32'h1000_FFFF);
        expect_store(32'h100, 32'hDEAD_BEEF);
        start_test(4'd3);
        n = 0;
        while (!(mem_if.mem_req && mem_if.mem_we) && n < 200) begin
            tick(1);
            n++;
        end
        check("sw_req_seen", 32'(mem_if.mem_req && mem_if.mem_we), 32'd1);
        stalled = 1'b0;
        for (int k = 0; k < 5; k++) begin
            check("sw_hold_req", 32'(mem_if.mem_req), 32'd1);
            check("sw_hold_we", 32'(mem_if.mem_we), 32'd1);
            check("sw_hold_addr", mem_if.mem_addr, 32'h100);
            check("sw_hold_data", mem_if.mem_wdata, 32'hDEAD_BEEF);
            if (mem_if.mem_ack && !stalled) begin
                en      = 1'b0;
                stalled = 1'b1;
            end else begin
                en = 1'b1;
            end
            tick(1);
        end
        en = 1'b1;
        check("stall_seen", 32'(stalled), 32'd1);
        wait_pc("lw_done_pc", 32'h10, 200);
        check("lw_dbg", dbg_reg, 32'hDEAD_BEEF);

        // Control flow.
        pw(32'h00, 32'h2402_0001);   // ADDIU $2,$0,1
        pw(32'h04, 32'h1442_0005);   // BNE $2,$2,+5 (not taken)
        pw(32'h08, 32'h0C00_0040);   // JAL 0x100
        pw(32'h0C, 32'h0800_0005);   // J 0x14
        pw(32'h10, 32'h1000_FFFF);   // park
        pw(32'h14, 32'h1000_FFFE);   // BEQ $0,$0,-2
        pw(32'h100, 32'h03E0_1021);  // ADDU $2,$31,$0
        pw(32'h104, 32'h03E0_0008);  // JR $31
        start_test(4'd0);
        wait_pc("addiu_pc", 32'h4, 20);
        wait_pc("bne_not_taken", 32'h8, 20);
        tick(2);
        check("jal_pc", pc, 32'h100);
        wait_pc("link_copy_pc", 32'h104, 20);
        check("jal_link", dbg_reg, 32'h0C);
        tick(2);
        check("jr_pc", pc, 32'h0C);
        tick(2);
        check("j_pc", pc, 32'h14);
        tick(3);
        check("beq_back_pc", pc, 32'h10);
        tick(3);
        check("park_pc", pc, 32'h10);

        // Signed overflow suppresses the write.
        pw(32'h00, 32'h3C02_7FFF);   // LUI $2,0x7FFF
        pw(32'h04, 32'h3442_FFFF);   // ORI $2,$2,0xFFFF
        pw(32'h08, 32'h2401_0001);   // ADDIU $1,$0,1
        pw(32'h0C, 32'h0041_1020);   // ADD  $2,$2,$1
        pw(32'h10, 32'h0041_1021);   // ADDU $2,$2,$1
        pw(32'h14, 32'h1000_FFFF);
        start_test(4'd0);
        wait_pc("add_ovf_pc", 32'h10, 50);
        check("add_ovf_dbg", dbg_reg, 32'h7FFF_FFFF);
        wait_pc("addu_pc", 32'h14, 50);
        check("addu_wrap", dbg_reg, 32'h8000_0000);

        // ALU mix, results observed through the store scoreboard.
        pw(32'h00, 32'h2401_FFFD);   // ADDIU $1,$0,-3
        pw(32'h04, 32'h2403_0005);   // ADDIU $3,$0,5
        pw(32'h08, 32'h0023_202A);   // SLT  $4,$1,$3
        pw(32'h0C, 32'hAC04_0200);
        pw(32'h10, 32'h0023_202B);   // SLTU $4,$1,$3
        pw(32'h14, 32'hAC04_0204);
        pw(32'h18, 32'h0001_2043);   // SRA  $4,$1,1
        pw(32'h1C, 32'hAC04_0208);
        pw(32'h20, 32'h0001_2102);   // SRL  $4,$1,4
        pw(32'h24, 32'hAC04_020C);
        pw(32'h28, 32'h0023_2027);   // NOR  $4,$1,$3
        pw(32'h2C, 32'hAC04_0210);
        pw(32'h30, 32'h3024_FFF0);   // ANDI $4,$1,0xFFF0
        pw(32'h34, 32'hAC04_0214);
        pw(32'h38, 32'h2824_FFFE);   // SLTI $4,$1,-2
        pw(32'h3C, 32'hAC04_0218);
        pw(32'h40, 32'h0061_2022);   // SUB  $4,$3,$1
        pw(32'h44, 32'hAC04_021C);
        pw(32'h48, 32'hAC00_0220);   // SW $0
        pw(32'h4C, 32'h1000_FFFF);
        expect_store(32'h200, 32'h0000_0001);
        expect_store(32'h204, 32'h0000_0000);
        expect_store(32'h208, 32'hFFFF_FFFE);
        expect_store(32'h20C, 32'h0FFF_FFFF);
        expect_store(32'h210, 32'h0000_0002);
        expect_store(32'h214, 32'h0000_FFF0);
        expect_store(32'h218, 32'h0000_0001);
        expect_store(32'h21C, 32'h0000_0008);
        expect_store(32'h220, 32'h0000_0000);
        start_test(4'd1);
        wait_pc("alu_mix_pc", 32'h4C, 1000);

        // Illegal opcode.
        pw(32'h00, 32'hFC00_0000);
        pw(32'h04, 32'h2402_0009);   // ADDIU $2,$0,9
        pw(32'h08, 32'h1000_FFFF);
        start_test(4'd0);
        tick(2);
`ifdef MIPS_MC_CORE_TRAP_EN
        check("trap_halted", 32'(halted), 32'd1);
        check("trap_req", 32'(mem_if.mem_req), 32'd0);
        check("trap_pc", pc, 32'h0);
        tick(3);
        check("trap_pc_held", pc, 32'h0);
        check("trap_still_halted", 32'(halted), 32'd1);
`else
        check("nop_pc", pc, 32'h4);
        check("nop_halted", 32'(halted), 32'd0);
        wait_pc("nop_next_pc", 32'h8, 20);
        check("nop_next_dbg", dbg_reg, 32'd9);
`endif

        check("sb_drain", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
